// File: rtl/serial_pkg.sv
// Shared types and sizing helpers for the serial transmit/capture path.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2,
        GAP   = 2'd3
    } state_t;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/shift_reg_piso.sv
// Load/shift register for the serializer; the outgoing bit is always at the edge chosen by MSB_FIRST.
// Zero latency from register to bit_out; load has priority over shift.
module shift_reg_piso #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             bit_out
);

    logic [WIDTH-1:0] q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            q <= MSB_FIRST ? {q[WIDTH-2:0], 1'b0} : {1'b0, q[WIDTH-1:1]};
        end
    end

    assign bit_out = MSB_FIRST ? q[WIDTH-1] : q[0];

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmit stage: first bit on sout one cycle after accept, frame_done after the last bit.
// Accepts only in IDLE; in_ready stays low through SHIFT, DONE and GAP_CYCLES idle cycles.
module piso_serializer
    import serial_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter bit MSB_FIRST  = 1'b0,
    parameter int GAP_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             sout,
    output logic             sout_en,
    output logic             frame_done,
    output logic             busy
);

    localparam int BW = cnt_width(WIDTH);
    localparam int GW = cnt_width(GAP_CYCLES);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t          state_q;
    state_t          state_d;
    logic [BW-1:0]   bit_cnt;
    logic [GW-1:0]   gap_cnt;
    logic            load;
    logic            shift;
    logic            bit_out;

    assign load  = (state_q == IDLE) && in_valid;
    assign shift = (state_q == SHIFT);

    shift_reg_piso #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift_reg (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .shift   (shift),
        .din     (din),
        .bit_out (bit_out)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (in_valid) state_d = SHIFT;
            SHIFT: if (bit_cnt == BIT_LAST) state_d = DONE;
            DONE:  state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
            GAP:   if (gap_cnt == GAP_LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            if (load) begin
                bit_cnt <= '0;
            end else if (shift) begin
                bit_cnt <= bit_cnt + BW'(1);
            end
            if (state_q == DONE) begin
                gap_cnt <= '0;
            end else if (state_q == GAP) begin
                gap_cnt <= gap_cnt + GW'(1);
            end
        end
    end

    // The shift register is loaded on the accept edge, so its output bit is already the first bit in SHIFT.
    assign sout       = shift & bit_out;
    assign sout_en    = shift;
    assign frame_done = (state_q == DONE);
    assign in_ready   = (state_q == IDLE);
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: three instances (LSB-first, MSB-first, no gap) plus a downstream 4-bit SIPO on instance 0.
module tb_piso_serializer;

    logic       clk;
    logic       rst;
    logic [3:0] din_a      [3];
    logic       vld_a      [3];
    logic       in_ready_a [3];
    logic       sout_a     [3];
    logic       sout_en_a  [3];
    logic       fdone_a    [3];
    logic       busy_a     [3];

    int nvec  = 0;
    int nfail = 0;
    int cyc   = 0;
    int last_acc = 0;

    logic [3:0] pout;
    logic [3:0] cap;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        piso_serializer #(
            .WIDTH      (4),
            .MSB_FIRST  (g == 1),
            .GAP_CYCLES ((g == 2) ? 0 : 1)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .din        (din_a[g]),
            .in_valid   (vld_a[g]),
            .in_ready   (in_ready_a[g]),
            .sout       (sout_a[g]),
            .sout_en    (sout_en_a[g]),
            .frame_done (fdone_a[g]),
            .busy       (busy_a[g])
        );
    end

    // Downstream right-shifting SIPO: sin enters at the MSB, frame_done captures the word.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pout <= '0;
            cap  <= '0;
        end else begin
            if (sout_en_a[0]) pout <= {sout_a[0], pout[3:1]};
            if (fdone_a[0])   cap  <= pout;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input int idx, input string tag);
        check({tag, "_in_ready"}, in_ready_a[idx], 1);
        check({tag, "_busy"}, busy_a[idx], 0);
        check({tag, "_sout"}, sout_a[idx], 0);
        check({tag, "_sout_en"}, sout_en_a[idx], 0);
        check({tag, "_frame_done"}, fdone_a[idx], 0);
    endtask

    // One full frame on instance idx, called at a negedge with the instance idle.
    task automatic send(input int idx, input logic [3:0] w, input bit keep,
                        input logic [3:0] nxt, input bit chk_sp);
        int   t;
        int   gap;
        int   pos;
        t   = 0;
        gap = (idx == 2) ? 0 : 1;
        while (!in_ready_a[idx] && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("ready_wait", in_ready_a[idx], 1);
        din_a[idx] = w;
        vld_a[idx] = 1'b1;
        if (chk_sp) check("accept_spacing", cyc - last_acc, 7);
        last_acc = cyc;
        @(negedge clk);
        din_a[idx] = nxt;
        vld_a[idx] = keep;
        for (int k = 0; k < 4; k++) begin
            pos = (idx == 1) ? 3 - k : k;
            check("bit_en", sout_en_a[idx], 1);
            check("bit_val", sout_a[idx], (w >> pos) & 1);
            check("shift_ready", in_ready_a[idx], 0);
            check("shift_busy", busy_a[idx], 1);
            check("shift_fdone", fdone_a[idx], 0);
            @(negedge clk);
        end
        check("done_fdone", fdone_a[idx], 1);
        check("done_sout_en", sout_en_a[idx], 0);
        check("done_sout", sout_a[idx], 0);
        check("done_busy", busy_a[idx], 1);
        check("done_ready", in_ready_a[idx], 0);
        @(negedge clk);
        if (idx == 0) check("sipo_pout", cap, w);
        for (int i = 0; i < gap; i++) begin
            check("gap_fdone", fdone_a[idx], 0);
            check("gap_ready", in_ready_a[idx], 0);
            check("gap_busy", busy_a[idx], 1);
            check("gap_sout_en", sout_en_a[idx], 0);
            @(negedge clk);
        end
        check("ret_ready", in_ready_a[idx], 1);
        check("ret_busy", busy_a[idx], 0);
        check("ret_fdone", fdone_a[idx], 0);
        check("ret_sout_en", sout_en_a[idx], 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] w;
        int         idx;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            din_a[i] = '0;
            vld_a[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) check_idle(i, "reset");
        rst = 1'b1;
        @(negedge clk);

        send(0, 4'b1101, 1'b0, 4'h0, 1'b0);
        send(1, 4'b1101, 1'b0, 4'h0, 1'b0);

        send(0, 4'h3, 1'b1, 4'hA, 1'b0);
        send(0, 4'hA, 1'b1, 4'h5, 1'b1);
        send(0, 4'h5, 1'b0, 4'h0, 1'b1);
        @(negedge clk);
        check_idle(0, "after_stream");

        send(0, 4'hF, 1'b0, 4'h0, 1'b0);
        send(2, 4'h9, 1'b0, 4'h6, 1'b0);

        // Reset in the middle of a frame, after two bits have gone out.
        din_a[0] = 4'b1001;
        vld_a[0] = 1'b1;
        @(negedge clk);
        vld_a[0] = 1'b0;
        check("mid_bit0", sout_a[0], 1);
        @(negedge clk);
        check("mid_bit1", sout_a[0], 0);
        rst = 1'b0;
        #1;
        check_idle(0, "mid_reset");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mid_reset_fdone", fdone_a[0], 0);
        end
        rst = 1'b1;
        @(negedge clk);
        check_idle(0, "mid_release");
        send(0, 4'b0110, 1'b0, 4'h0, 1'b0);

        for (int n = 0; n < 30; n++) begin
            idx = $urandom_range(0, 2);
            w   = 4'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(idx, w, 1'b0, 4'($urandom), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in serial-out transmit stage that sits directly upstream of the 4-bit serial-in/parallel-out capture register.
- Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock.
- Emits a one-cycle frame_done strobe after the last bit. The downstream SIPO uses this strobe as its mode/capture control.
- Default bit order is LSB-first, so a downstream right-shifting SIPO (sin enters at MSB) ends up holding the word in its original bit order.

Parameters:
- WIDTH, 4, word width in bits; legal range >= 2.
- MSB_FIRST, 0, 0 = transmit din[0] first; 1 = transmit din[WIDTH-1] first.
- GAP_CYCLES, 1, idle cycles after frame_done before in_ready re-asserts; 0 is legal.

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- din  input  WIDTH  parallel word; sampled only on the accept edge.
- in_valid  input  1  din is valid.
- in_ready  output  1  block can accept a word (high only in IDLE).
- sout  output  1  serial data bit.
- sout_en  output  1  sout carries a valid bit this cycle (downstream shift enable).
- frame_done  output  1  one-cycle pulse in the cycle after the last bit.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE; shift register and counters clear.
  - sout=0, sout_en=0, frame_done=0, busy=0, in_ready=1.
  - Applies immediately at any point, including mid-frame. The partial frame is dropped and no frame_done is issued.
- States: IDLE, SHIFT, DONE, GAP. All outputs are registered or decoded from registered state; there is no combinational path from din/in_valid to any output.
- IDLE:
  - in_ready=1, sout_en=0, sout=0.
  - Accept edge: in_valid=1 and in_ready=1 at a rising clk edge.
  - On the accept edge: din is copied to an internal shift register, bit counter set to 0, next state SHIFT.
  - At that same edge sout is loaded with the first bit (din[0], or din[WIDTH-1] if MSB_FIRST) and sout_en goes to 1.
- SHIFT:
  - Latency: the first bit is on sout in the cycle immediately after the accept edge.
  - sout_en=1 for exactly WIDTH consecutive cycles, one new bit per edge. Bit k (k = 0..WIDTH-1 in transmit order) appears k+1 cycles after accept.
  - in_ready=0. in_valid and din are ignored; din may change freely after the accept edge.
  - Bit counter width is $clog2(WIDTH). When the counter reaches WIDTH-1, the next edge goes to DONE.
- DONE:
  - Lasts exactly 1 cycle.
  - sout_en=0, sout=0, frame_done=1, in_ready=0.
  - Next state is GAP if GAP_CYCLES>0, otherwise IDLE.
- GAP:
  - Lasts GAP_CYCLES cycles, counted with its own counter.
  - All outputs idle; in_ready=0.
  - Then IDLE.
- Back-to-back throughput: the minimum accept-to-accept spacing is WIDTH + 2 + GAP_CYCLES cycles.
- busy=1 in SHIFT, DONE and GAP.
- in_valid held high continuously: a new word is accepted on the first edge after the return to IDLE (the edge following in_ready going high). No word is ever lost or duplicated.
- Downstream timing: sout/sout_en change just after a rising edge. A downstream SIPO clocked on the same edge therefore samples each bit one cycle later, and samples frame_done in the cycle after the last bit.

Decomposition:
- Shared package serial_pkg:
  - State enum typedef (IDLE, SHIFT, DONE, GAP).
  - Localparam function for counter width, $clog2 with a minimum of 1.
- Natural sub-module: shift_reg_piso, holding the load/shift register and the first-bit select, parameterised by WIDTH and MSB_FIRST.
- The FSM, both counters and the output registers stay in piso_serializer.

Test Plan:
- Reset then single word: rst low 2 cycles; WIDTH=4, din=4'b1101 with one-cycle in_valid pulse.
  - Required: sout = 1,0,1,1 on the 4 cycles after accept, with sout_en=1 on exactly those 4 cycles.
  - Required: frame_done=1 on cycle 5; in_ready high again on cycle 7 (GAP_CYCLES=1).
- MSB_FIRST=1, din=4'b1101 -> sout = 1,1,0,1.
- Continuous in_valid=1 with din stepping 4'h3, 4'hA, 4'h5 on each accept.
  - Required: three frames 7 cycles apart; serial streams 1100, 0101, 1010 (LSB-first).
  - Required: three frame_done pulses.
- din changed to 4'h0 on the cycle after accept of 4'hF -> sout stays 1,1,1,1.
- rst asserted low after the 2nd bit of a frame.
  - Required: sout=0, sout_en=0, in_ready=1 immediately; no frame_done.
  - Required: the next word after reset release is sent intact.
- Loopback to the downstream 4-bit SIPO, with SIPO mode driven by frame_done.
  - Required: SIPO pout equals din (4'b1101 and 4'b0110) on the cycle after each frame_done.
